// File: rtl/wb_master_bridge.sv
// Valid/ready command to Wishbone classic single-transfer bridge: cyc/stb 1 cycle after accept, response 1 cycle after ack/err/timeout.
// Backpressure: one transaction in flight; req_ready_o stays low until the response is taken via rsp_ready_i.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i,

    output logic        busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
    localparam logic        TO_EN  = (TIMEOUT != 0);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic        bus_timeout;
    logic        bus_done;

    // Timeout only fires when the responder is silent; ack/err win in the same cycle.
    always_comb begin
        bus_timeout = TO_EN && (wait_cnt == TO_LIM) && !wbm_ack_i && !wbm_err_i;
        bus_done    = wbm_ack_i || wbm_err_i || bus_timeout;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 16'h0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= 32'h0;
            rsp_err_o   <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= 32'h0;
            wbm_dat_o   <= 32'h0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        state       <= S_BUS;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        wait_cnt    <= 16'h0;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= req_we_i;
                        wbm_sel_o   <= req_sel_i;
                        wbm_adr_o   <= req_adr_i;
                        wbm_dat_o   <= req_dat_i;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        state       <= S_RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        // Timeout leaves ack low, so it reports as an error too.
                        rsp_err_o   <= wbm_err_i || !wbm_ack_i;
                        rsp_dat_o   <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : 32'h0;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'h1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= S_IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    req_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: vector table of Wishbone transactions with a response scoreboard, plus reset corner cases.
`timescale 1ns/1ps
module tb_wb_master_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [3:0]  req_sel = 4'h0;
    logic [31:0] req_adr = 32'h0, req_dat = 32'h0;
    logic        req_ready;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we, busy;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack = 1'b0, err = 1'b0;
    logic [31:0] rdat = 32'h0;

    wb_master_bridge #(.TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_sel_i   (req_sel),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_ack_i   (ack),
        .wbm_err_i   (err),
        .wbm_dat_i   (rdat),
        .busy_o      (busy)
    );

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent responder. term: bus cycle of termination (accept = cycle 0).
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          kind;
        int          term;
        logic [31:0] rdata;
        int          bp;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int   n;
        bit   ok;
        exp_t e;
        logic [31:0] hold_dat;
        logic        hold_err;

        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d req_ready idle", idx), {31'h0, req_ready}, 32'h1);

        req_valid = 1'b1;
        req_we    = v.we;
        req_sel   = v.sel;
        req_adr   = v.adr;
        req_dat   = v.dat;
        sb.push_back('{v.exp_dat, v.exp_err});
        @(negedge clk);

        // Junk command held valid during the whole transaction must be ignored.
        req_we  = ~v.we;
        req_sel = ~v.sel;
        req_adr = ~v.adr;
        req_dat = ~v.dat;

        ok = 1'b1;
        for (n = 1; n <= 40; n++) begin
            if (cyc !== 1'b1) break;
            if (stb !== 1'b1 || we !== v.we || sel !== v.sel || adr !== v.adr ||
                wdat !== v.dat || busy !== 1'b1 || req_ready !== 1'b0)
                ok = 1'b0;
            ack  = (n == v.term) && (v.kind == 0 || v.kind == 2);
            err  = (n == v.term) && (v.kind == 1 || v.kind == 2);
            rdat = (n == v.term) ? v.rdata : ~v.rdata;
            @(negedge clk);
            ack = 1'b0;
            err = 1'b0;
        end
        chk($sformatf("v%0d bus fields", idx), {31'h0, ok}, 32'h1);
        chk($sformatf("v%0d term cycle", idx), 32'(n), 32'(v.term + 1));
        chk($sformatf("v%0d rsp_valid", idx), {31'h0, rsp_valid}, 32'h1);

        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", idx), 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d rsp_dat", idx), rsp_dat, e.dat);
            chk($sformatf("v%0d rsp_err", idx), {31'h0, rsp_err}, {31'h0, e.err});
        end

        if (v.bp > 0) begin
            hold_dat = rsp_dat;
            hold_err = rsp_err;
            ok = 1'b1;
            for (int i = 0; i < v.bp; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_dat !== hold_dat || rsp_err !== hold_err ||
                    req_ready !== 1'b0 || cyc !== 1'b0 || busy !== 1'b1)
                    ok = 1'b0;
            end
            chk($sformatf("v%0d backpressure hold", idx), {31'h0, ok}, 32'h1);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_valid drop", idx), {31'h0, rsp_valid}, 32'h0);
        chk($sformatf("v%0d ready return", idx), {30'h0, req_ready, busy}, 32'h2);
    endtask

    initial begin
        bit ok;

        vecs[0] = '{1'b0, 4'hF,    32'h3000_0004, 32'h0,         0, 3, 32'hCAFE_F00D, 0,  32'hCAFE_F00D, 1'b0};
        vecs[1] = '{1'b1, 4'b0011, 32'h3000_0000, 32'h1234_5678, 0, 1, 32'hDEAD_BEEF, 0,  32'h0,         1'b0};
        vecs[2] = '{1'b0, 4'hF,    32'h3000_0008, 32'h0,         1, 2, 32'h1111_2222, 0,  32'h0,         1'b1};
        vecs[3] = '{1'b0, 4'hF,    32'h3000_000C, 32'h0,         2, 2, 32'h55AA_55AA, 10, 32'h0,         1'b1};
        vecs[4] = '{1'b0, 4'hF,    32'h3000_0010, 32'h0,         3, 5, 32'h7777_8888, 0,  32'h0,         1'b1};
        vecs[5] = '{1'b0, 4'b1000, 32'h3000_0014, 32'h0,         0, 5, 32'h0BAD_F00D, 0,  32'h0BAD_F00D, 1'b0};
        vecs[6] = '{1'b1, 4'hF,    32'h3000_0018, 32'hA5A5_A5A5, 1, 4, 32'h1357_9BDF, 2,  32'h0,         1'b1};

        // Reset state
        #12;
        chk("reset ctl outputs", {25'h0, cyc, stb, we, rsp_valid, rsp_err, busy, req_ready}, 32'h0);
        chk("reset adr", adr, 32'h0);
        chk("reset rsp_dat", rsp_dat, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready before first edge", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("ready after first edge", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 7; i++) do_txn(vecs[i], i);

        // Responder strobes while idle must not create a transaction or response
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ack = 1'b1;
            err = (i == 2);
            rdat = 32'hFFFF_0000;
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cyc !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
        end
        ack = 1'b0;
        err = 1'b0;
        chk("idle ack ignored", {31'h0, ok}, 32'h1);

        // Reset in the middle of a bus cycle
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_sel   = 4'hF;
        req_adr   = 32'h3000_0020;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid-bus cyc before reset", {30'h0, cyc, busy}, 32'h3);
        #1 rst_n = 1'b0;
        #1;
        chk("reset mid-bus outputs", {28'h0, cyc, stb, busy, req_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cyc !== 1'b0) ok = 1'b0;
        end
        chk("no rsp after reset", {31'h0, ok}, 32'h1);
        do_txn(vecs[0], 7);

        chk("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
